vram_banked_arb: RTL
====================

// Module: vram_banked_arb
// PURPOSE
//  Parametrised banked video RAM with two access ports: a fixed-priority video read port
//  and a CPU read/write port with req/ack handshake and byte write mask. Banks are selected
//  by top address bits. The CPU proceeds in the same cycle as video when the two hit
//  different banks, and waits only on a bank conflict. Sits between the video scan-out
//  engine and the register/bus interface.
// PARAMETERS
//  DATA_W   16  word width; multiple of 8
//  ADDR_W   16  word address width
//  BANKS    4   bank count, power of 2, 1..16; bank = addr[ADDR_W-1 -: log2(BANKS)]
// PORTS
//  clk           in   1           system clock; all logic on rising edge
//  reset         in   1           asynchronous, active-high reset
//  vid_sel       in   1           video read request this cycle; always granted
//  vid_addr      in   ADDR_W      video word address
//  vid_data      out  DATA_W      video read data; meaningful only while vid_valid=1
//  vid_valid     out  1           vid_data holds mem[vid_addr of previous cycle]
//  cpu_req       in   1           CPU request; hold with stable fields until cpu_ack
//  cpu_wr        in   1           1=write, 0=read
//  cpu_addr      in   ADDR_W      CPU word address
//  cpu_data_in   in   DATA_W      CPU write data
//  cpu_mask      in   DATA_W/8    byte write enables; bit i covers data[8i+7:8i]
//  cpu_ack       out  1           one-cycle completion pulse
//  cpu_data_out  out  DATA_W      CPU read data; valid in ack cycle, held until next read ack
// BEHAVIOUR
//  - Reset: vid_valid=0, cpu_ack=0, cpu_data_out=0, FSM=IDLE. Memory contents are not cleared.
//  - Reset aborts any in-flight or latched CPU write; that write may or may not land.
//  - Video: vid_sel=1 at cycle N enables bank(vid_addr). vid_valid=1 and vid_data=mem at N+1.
//    There are no video stalls.
//  - Conflict at cycle N: vid_sel=1 && bank(vid_addr)==bank(CPU address). With BANKS=1, any vid_sel is a conflict.
//  - CPU FSM:
//    IDLE: samples cpu_req. Latches addr/data/mask/wr.
//      No conflict: issue this cycle and go to ACK.
//      Conflict: go to WAIT.
//    WAIT: issue the latched access in the first conflict-free cycle, then go to ACK.
//    ACK: cpu_ack=1 for exactly one cycle.
//      Read: cpu_data_out = mem[addr] as read at the issue cycle.
//      Write: the masked write has committed.
//      Next state is IDLE. cpu_req is ignored in ACK; if still high in IDLE it is a new request.
//  - Minimum CPU access is 2 cycles (issue, ack). WAIT is unbounded while video holds the bank.
//  - Write: only bytes with cpu_mask=1 change. A mask of 0 completes with ack and changes no data.
//  - A video read and a CPU write to the same bank never occur in the same cycle.
//  - Synthesis: one SB_SPRAM256KA per bank when DATA_W=16 and bank depth is 16K words; otherwise an inferred array.
//  - Simulation (!SYNTHESIS): a behavioural array with the same cycle behaviour.
// CONFIGURATION
//  VRAM_WRITE_BUF_EN defined: single-entry posted write buffer.
//   - A CPU write in IDLE is captured into the buffer and acked at N+1 regardless of conflict.
//   - The buffer drains in the first conflict-free cycle using the buffered address.
//   - While the buffer is full, IDLE does not sample cpu_req. A read never overtakes a
//     buffered write.
//   - Reset empties the buffer.
//  VRAM_WRITE_BUF_EN undefined: writes are acked only after commit, as described in BEHAVIOUR.
// TESTING
//  1. Reset, CPU write 0x1234 to 0x0010 (no video), then vid_sel=1 addr 0x0010 -> next cycle
//     vid_valid=1, vid_data=0x1234.
//  2. vid_sel=1 addr 0x0100 for 5 cycles; CPU write 0x5555 to 0x0200 (same bank) ->
//     no cpu_ack while vid_sel=1; ack in the cycle after the first vid_sel=0 cycle;
//     readback 0x5555.
//  3. vid_sel=1 addr 0x4000 (bank 1) continuously; CPU read 0x0000 (bank 0, holds 0xBEEF) ->
//     cpu_ack at N+1 with 0xBEEF; vid_valid stays 1 throughout.
//  4. mem[0x0020]=0xABCD; write 0x1234 with mask 2'b01 -> read returns 0xAB34.
//     Mask 2'b00 -> ack and data unchanged.
//  5. Assert reset while the FSM is in WAIT -> cpu_ack=0 and vid_valid=0 immediately.
//     After release, a new read request gets ack 2 cycles later with correct data.
//  6. (VRAM_WRITE_BUF_EN) With video on bank 0, write 0x7777 to 0x0030 -> ack at N+1.
//     An immediately following read of 0x0030 waits until the drain, then returns 0x7777.

Source files
------------

// File: rtl/vram_banked_arb_if.sv
// ---------------------------------------------------------------------------
// vram_banked_arb_if
//   Bundles the video read port and the CPU req/ack port of vram_banked_arb.
//   master : scan-out engine / bus side (drives requests, receives data)
//   slave  : the banked VRAM arbiter
// Signals
//   vid_sel, vid_addr            video read request and word address
//   vid_data, vid_valid          video read data, valid one cycle after vid_sel
//   cpu_req, cpu_wr, cpu_addr    CPU request, direction, word address
//   cpu_data_in, cpu_mask        CPU write data and byte enables
//   cpu_ack, cpu_data_out        completion pulse and CPU read data
// ---------------------------------------------------------------------------
interface vram_banked_arb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic                vid_sel;
    logic [ADDR_W-1:0]   vid_addr;
    logic [DATA_W-1:0]   vid_data;
    logic                vid_valid;
    logic                cpu_req;
    logic                cpu_wr;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [DATA_W-1:0]   cpu_data_in;
    logic [DATA_W/8-1:0] cpu_mask;
    logic                cpu_ack;
    logic [DATA_W-1:0]   cpu_data_out;

    modport master (
        output vid_sel, vid_addr, cpu_req, cpu_wr, cpu_addr, cpu_data_in, cpu_mask,
        input  vid_data, vid_valid, cpu_ack, cpu_data_out
    );

    modport slave (
        input  vid_sel, vid_addr, cpu_req, cpu_wr, cpu_addr, cpu_data_in, cpu_mask,
        output vid_data, vid_valid, cpu_ack, cpu_data_out
    );
endinterface

// File: rtl/vram_banked_arb.sv
// ---------------------------------------------------------------------------
// vram_banked_arb
//   Banked video RAM shared between a fixed-priority video read port and a
//   CPU read/write port. The bank is chosen by the top address bits. Video is
//   never stalled; the CPU runs in parallel when it targets a different bank
//   and waits only while video occupies its bank.
// Ports
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    vram_banked_arb_if.slave (video port + CPU req/ack port)
// Parameters
//   DATA_W word width (multiple of 8), ADDR_W word address width,
//   BANKS  bank count (power of 2, 1..16)
// Build option
//   VRAM_WRITE_BUF_EN : single-entry posted CPU write buffer. Writes are
//   acked one cycle after the request and drained in the first cycle the
//   video port leaves the target bank alone. New requests are held off
//   while the buffer is full, so a read can never overtake a buffered write.
// Memory
//   Under SYNTHESIS, 16-bit banks of 16K words map onto SB_SPRAM256KA; all
//   other shapes (and simulation) use an inferred array with registered read.
// ---------------------------------------------------------------------------
module vram_banked_arb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int BANKS  = 4
) (
    input  logic             clk,
    input  logic             reset,
    vram_banked_arb_if.slave bus
);
    localparam int NB     = DATA_W / 8;
    localparam int SEL_W  = $clog2(BANKS);
    localparam int BANK_W = (BANKS > 1) ? SEL_W : 1;
    localparam int LOC_W  = ADDR_W - SEL_W;
    localparam int DEPTH  = 1 << LOC_W;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
        if (BANKS == 1) return '0;
        return a[ADDR_W-1 -: BANK_W];
    endfunction

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [NB-1:0]       mask_reg;
    logic                wr_reg;
    logic [DATA_W-1:0]   data_hold_reg;
    logic                vid_valid_reg;
    logic [BANK_W-1:0]   vid_bank_reg;

    logic                capture, cpu_issue, cpu_conflict, buf_busy, buf_drain;
    logic [BANK_W-1:0]   vid_bank;
    logic [ADDR_W-1:0]   iss_addr;
    logic [DATA_W-1:0]   iss_wdata;
    logic [NB-1:0]       iss_mask;
    logic                iss_wr;
    logic                port_en, port_we;
    logic [ADDR_W-1:0]   port_addr;
    logic [DATA_W-1:0]   port_wdata;
    logic [NB-1:0]       port_mask;
    logic [DATA_W-1:0]   cpu_rdata;
    logic [DATA_W-1:0]   bank_rdata [BANKS];

    assign vid_bank = bank_of(bus.vid_addr);

    // IDLE issues straight from the live request so a conflict-free access
    // costs only the issue cycle; WAIT replays the latched copy.
    assign iss_addr  = (state_reg == ST_IDLE) ? bus.cpu_addr    : addr_reg;
    assign iss_wdata = (state_reg == ST_IDLE) ? bus.cpu_data_in : wdata_reg;
    assign iss_mask  = (state_reg == ST_IDLE) ? bus.cpu_mask    : mask_reg;
    assign iss_wr    = (state_reg == ST_IDLE) ? bus.cpu_wr      : wr_reg;

    assign cpu_conflict = bus.vid_sel && (vid_bank == bank_of(iss_addr));

`ifdef VRAM_WRITE_BUF_EN
    logic buf_full_reg, buf_load;

    // The latched request registers double as the buffer entry: nothing
    // else is captured while the buffer is full.
    assign buf_busy  = buf_full_reg;
    assign buf_drain = buf_full_reg && !(bus.vid_sel && (vid_bank == bank_of(addr_reg)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            buf_full_reg <= 1'b0;
        else if (buf_load)
            buf_full_reg <= 1'b1;
        else if (buf_drain)
            buf_full_reg <= 1'b0;
    end
`else
    assign buf_busy  = 1'b0;
    assign buf_drain = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        cpu_issue  = 1'b0;
`ifdef VRAM_WRITE_BUF_EN
        buf_load   = 1'b0;
`endif
        unique case (state_reg)
            ST_IDLE: begin
                if (bus.cpu_req && !buf_busy) begin
                    capture = 1'b1;
`ifdef VRAM_WRITE_BUF_EN
                    if (bus.cpu_wr) begin
                        buf_load   = 1'b1;
                        state_next = ST_ACK;
                    end else
`endif
                    if (!cpu_conflict) begin
                        cpu_issue  = 1'b1;
                        state_next = ST_ACK;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!cpu_conflict) begin
                    cpu_issue  = 1'b1;
                    state_next = ST_ACK;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // CPU-side bank port: a direct issue and a buffer drain are mutually
    // exclusive because requests are not accepted while the buffer is full.
    assign port_en    = cpu_issue || buf_drain;
    assign port_we    = buf_drain || iss_wr;
    assign port_addr  = buf_drain ? addr_reg  : iss_addr;
    assign port_wdata = buf_drain ? wdata_reg : iss_wdata;
    assign port_mask  = buf_drain ? mask_reg  : iss_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            vid_valid_reg <= 1'b0;
            data_hold_reg <= '0;
        end else begin
            state_reg     <= state_next;
            vid_valid_reg <= bus.vid_sel;
            if (state_reg == ST_ACK && !wr_reg)
                data_hold_reg <= cpu_rdata;
        end
    end

    always_ff @(posedge clk) begin
        vid_bank_reg <= vid_bank;
        if (capture) begin
            addr_reg  <= bus.cpu_addr;
            wdata_reg <= bus.cpu_data_in;
            mask_reg  <= bus.cpu_mask;
            wr_reg    <= bus.cpu_wr;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BANKS; gi++) begin : g_bank
            logic              vid_hit, cpu_hit, en, we;
            logic [LOC_W-1:0]  addr;

            // Video wins the bank; the FSM guarantees the CPU never hits it
            // in the same cycle.
            assign vid_hit = bus.vid_sel && (vid_bank == BANK_W'(gi));
            assign cpu_hit = port_en && (bank_of(port_addr) == BANK_W'(gi));
            assign en      = vid_hit || cpu_hit;
            assign we      = cpu_hit && port_we;
            assign addr    = vid_hit ? bus.vid_addr[LOC_W-1:0] : port_addr[LOC_W-1:0];

`ifdef SYNTHESIS
            if (DATA_W == 16 && LOC_W == 14) begin : g_spram
                SB_SPRAM256KA u_spram (
                    .ADDRESS    (addr),
                    .DATAIN     (port_wdata),
                    .MASKWREN   ({{2{port_mask[1]}}, {2{port_mask[0]}}}),
                    .WREN       (we),
                    .CHIPSELECT (en),
                    .CLOCK      (clk),
                    .STANDBY    (1'b0),
                    .SLEEP      (1'b0),
                    .POWEROFF   (1'b1),
                    .DATAOUT    (bank_rdata[gi])
                );
            end else
`endif
            begin : g_array
                logic [DATA_W-1:0] mem [DEPTH];
                logic [DATA_W-1:0] rdata_reg;

                always_ff @(posedge clk) begin
                    if (en) begin
                        if (we) begin
                            for (int b = 0; b < NB; b++)
                                if (port_mask[b])
                                    mem[addr][8*b +: 8] <= port_wdata[8*b +: 8];
                        end else begin
                            rdata_reg <= mem[addr];
                        end
                    end
                end

                assign bank_rdata[gi] = rdata_reg;
            end
        end
    endgenerate

    assign cpu_rdata        = bank_rdata[bank_of(addr_reg)];
    assign bus.cpu_ack      = (state_reg == ST_ACK);
    // Read data is taken live from the bank in the ack cycle and held after.
    assign bus.cpu_data_out = (state_reg == ST_ACK && !wr_reg) ? cpu_rdata : data_hold_reg;
    assign bus.vid_valid    = vid_valid_reg;
    assign bus.vid_data     = bank_rdata[vid_bank_reg];
endmodule
